uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide).
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two, at least 2.
REQ-006 SHALL have the following ports, clock and reset first:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rxd  input  1  asynchronous serial line; idles high.
- rx_read_en  input  1  pop strobe for the head entry.
- rx_data  output  DATA_BITS  head-entry data, LSB = first bit received.
- rx_valid  output  1  FIFO not empty.
- rx_frame_err  output  1  head entry had stop bit = 0.
- rx_parity_err  output  1  head entry failed the parity check; always 0 when PARITY = 0.
- overrun  output  1  sticky flag: a frame was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- debug_state  output  3  current receiver FSM state encoding.

Function
REQ-007 SHALL pass rxd through a 2-flop synchroniser; the FSM uses only the synchronised value.
REQ-008 SHALL implement FSM states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
REQ-009 IDLE: on synchronised rxd = 0, SHALL clear the bit counter and go to START.
REQ-010 START: at count CLKS_PER_BIT/2, SHALL check rxd. If 0, go to DATA with the counter cleared. If 1 (glitch), go to IDLE.
REQ-011 DATA: SHALL sample one bit each CLKS_PER_BIT clocks, LSB first, DATA_BITS samples in total. Then go to PARITY if PARITY != 0, else go to STOP.
REQ-012 PARITY: SHALL sample one bit after CLKS_PER_BIT clocks. Error if the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
REQ-013 STOP: SHALL sample after CLKS_PER_BIT clocks and push {data, frame_err, parity_err} in that same cycle. frame_err = (sample == 0).
REQ-014 STOP exit: if the stop sample = 1, SHALL go to IDLE. If 0, SHALL go to BREAK.
REQ-015 BREAK: SHALL stay until synchronised rxd = 1, then go to IDLE, so that a held-low line yields exactly one frame.
REQ-016 FIFO SHALL be show-ahead: rx_data and both error flags reflect the head entry whenever rx_valid = 1. Their value when rx_valid = 0 is don't-care.
REQ-017 rx_valid SHALL rise on the clock edge after the stop-sample cycle; latency push-to-visible is 1 clk.
REQ-018 rx_read_en with rx_valid = 1 SHALL pop one entry. rx_read_en with rx_valid = 0 SHALL be ignored with no state change.
REQ-019 Simultaneous push and pop SHALL both occur; fifo_count is unchanged. This holds when full, so no overrun occurs.
REQ-020 Push when full without a pop SHALL drop the new frame, keep the existing contents, and set overrun.
REQ-021 overrun SHALL stay set until the next accepted pop clears it. If a pop and a new overrun occur in the same cycle, the set wins.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL range 0..FIFO_DEPTH.
REQ-023 The bit counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and never overflow.

Reset
REQ-024 Asserting reset (low) at any time, including mid-frame, SHALL asynchronously force:
- FSM to IDLE;
- counters, pointers and fifo_count to 0;
- rx_valid, overrun, rx_frame_err and rx_parity_err to 0;
- rx_data to 0;
- both synchroniser flops to 1.
REQ-025 After reset deasserts, a partially received frame SHALL be discarded, and reception SHALL resume at the next falling edge.

Structure
REQ-026 A shared package SHALL hold the FSM state encodings and the PARITY mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-027 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width (DATA_BITS+2) and depth, and exposing push, pop, full, empty and count.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10; DATA_BITS=8)
REQ-028 PARITY=0, send 0xA5 with a good stop bit. Required: rx_valid=1, rx_data=0xA5, both error flags 0. Then pulse rx_read_en for 1 clk. Required: rx_valid=0, fifo_count=0.
REQ-029 PARITY=2, send 0x03 with parity bit 1. Required: rx_parity_err=1, rx_data=0x03.
REQ-029 (continued) Send 0x03 with parity bit 0. Required: rx_parity_err=0.
REQ-030 Send 0x55 with stop bit 0, then hold rxd low for 50 bit times. Required: exactly one entry, rx_frame_err=1, FSM in BREAK until rxd returns high.
REQ-031 FIFO_DEPTH=4, no reads, send 5 frames 0x01..0x05. Required: fifo_count=4, overrun=1. Four pops return 0x01..0x04. overrun clears on the first pop.
REQ-032 FIFO full; pop in the same cycle as the 5th frame's push. Required: fifo_count stays 4, overrun=0, 0x05 is last in order.
REQ-033 Reset asserted during data bit 4 of a frame, then released. Required: all outputs 0, FSM IDLE. The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receiver with FIFO.
// Receiver FSM state encodings and parity mode constants.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Pops are ignored when empty; a push while full lands only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // Storage, pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, framing FSM, parity check,
// and a show-ahead receive FIFO with sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rx_read_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    debug_state
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_BITS) + 1;
  localparam int FW  = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] TOPB = BW'(DATA_BITS - 1);

  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bits, bits_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 sync1, rxs;
  logic                 push, ferr;
  logic                 full, empty, pop_ok;
  logic [FW-1:0]        head;

  // Two-flop synchroniser; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      bits  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      shreg <= shreg_n;
      perr  <= perr_n;
    end
  end

  // Next-state, sampling and push generation.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits;
    shreg_n = shreg;
    perr_n  = perr;
    push    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bits_n  = '0;
          perr_n  = 1'b0;
          state_n = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[DATA_BITS-1:1]};
          bits_n  = bits + BW'(1);
          if (bits == TOPB)
            state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          perr_n  = (PARITY == PAR_ODD) ? ~(^shreg ^ rxs)
                                        : (^shreg ^ rxs);
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          push    = 1'b1;
          ferr    = ~rxs;
          state_n = rxs ? S_IDLE : S_BREAK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pop_ok = rx_read_en & ~empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({shreg, ferr, perr}),
    .pop   (rx_read_en),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Sticky overrun: set on a dropped frame, cleared by an accepted pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overrun <= 1'b0;
    else if (push && full && !pop_ok)
      overrun <= 1'b1;
    else if (pop_ok)
      overrun <= 1'b0;
  end

  assign rx_valid      = ~empty;
  assign rx_data       = head[FW-1:2];
  assign rx_frame_err  = head[1];
  assign rx_parity_err = head[0];
  assign debug_state   = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (no/odd/even parity)
// driven with directed and random frames against a queue model.
module tb_uart_rx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd   [3];
  logic       rd    [3];
  logic [7:0] data  [3];
  logic       valid [3];
  logic       ferr  [3];
  logic       perr  [3];
  logic       ovr   [3];
  logic [2:0] cnt   [3];
  logic [2:0] st    [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] mq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_fifo #(
      .CLK_FREQ   (1_000_000),
      .BAUD_RATE  (100_000),
      .DATA_BITS  (8),
      .PARITY     (g),
      .FIFO_DEPTH (4)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .rxd           (rxd[g]),
      .rx_read_en    (rd[g]),
      .rx_data       (data[g]),
      .rx_valid      (valid[g]),
      .rx_frame_err  (ferr[g]),
      .rx_parity_err (perr[g]),
      .overrun       (ovr[g]),
      .fifo_count    (cnt[g]),
      .debug_state   (st[g])
    );
  end

  // Expected entry {data, frame_err, parity_err}; mode 0 none, 1 odd, 2 even.
  function automatic logic [9:0] model_entry(input int mode,
      input logic [7:0] d, input logic p, input logic stop);
    int ones;
    logic pe;
    ones = $countones(d) + int'(p);
    if (mode == 1)      pe = (ones % 2 == 0);
    else if (mode == 2) pe = (ones % 2 == 1);
    else                pe = 1'b0;
    return {d, ~stop, pe};
  endfunction

  task automatic send_frame(input int k, input logic [7:0] d,
      input logic p, input logic stop, input logic keep_low);
    @(negedge clk);
    rxd[k] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd[k] = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (k != 0) begin
      rxd[k] = p;
      repeat (CPB) @(negedge clk);
    end
    rxd[k] = stop;
    repeat (CPB) @(negedge clk);
    if (!keep_low) rxd[k] = 1'b1;
  endtask

  task automatic pop(input int k);
    rd[k] = 1'b1;
    @(negedge clk);
    rd[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rxd[k] = 1'b1;
      rd[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({valid[k], data[k], ferr[k], perr[k], ovr[k], cnt[k], st[k]}
          !== 17'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got v=%b d=%h f=%b p=%b o=%b c=%0d s=%0d expected all 0",
                 k, valid[k], data[k], ferr[k], perr[k], ovr[k], cnt[k], st[k]);
      end
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({valid[0], data[0], ferr[0], perr[0]} !== {1'b1, 8'hA5, 2'b00}) begin
      n_fail++;
      $display("FAIL basic_rx: got v=%b d=%h f=%b p=%b expected v=1 d=a5 f=0 p=0",
               valid[0], data[0], ferr[0], perr[0]);
    end
    pop(0);
    n_chk++;
    if ({valid[0], cnt[0]} !== 4'b0_000) begin
      n_fail++;
      $display("FAIL basic_pop: got v=%b c=%0d expected v=0 c=0", valid[0], cnt[0]);
    end
    pop(0);
    n_chk++;
    if ({valid[0], cnt[0], ovr[0]} !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_pop: got v=%b c=%0d o=%b expected 0 0 0",
               valid[0], cnt[0], ovr[0]);
    end
  endtask

  task automatic test_parity();
    logic [9:0] exp;
    for (int k = 1; k < 3; k++) begin
      for (int pb = 1; pb >= 0; pb--) begin
        send_frame(k, 8'h03, 1'(pb), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        exp = model_entry(k, 8'h03, 1'(pb), 1'b1);
        n_chk++;
        if ({data[k], ferr[k], perr[k]} !== exp || valid[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL parity[mode %0d pbit %0d]: got v=%b entry=%h expected v=1 entry=%h",
                   k, pb, valid[k], {data[k], ferr[k], perr[k]}, exp);
        end
        pop(k);
      end
    end
  endtask

  task automatic test_break();
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 50; b++) begin
      repeat (CPB) @(negedge clk);
      if (b == 1 || b == 25 || b == 49) begin
        n_chk++;
        if ({st[0], cnt[0]} !== {3'd5, 3'd1}) begin
          n_fail++;
          $display("FAIL break_hold[%0d]: got s=%0d c=%0d expected s=5 c=1", b, st[0], cnt[0]);
        end
      end
    end
    n_chk++;
    if ({data[0], ferr[0], perr[0]} !== {8'h55, 2'b10}) begin
      n_fail++;
      $display("FAIL break_entry: got d=%h f=%b p=%b expected d=55 f=1 p=0",
               data[0], ferr[0], perr[0]);
    end
    rxd[0] = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({st[0], cnt[0]} !== {3'd0, 3'd1}) begin
      n_fail++;
      $display("FAIL break_exit: got s=%0d c=%0d expected s=0 c=1", st[0], cnt[0]);
    end
    pop(0);
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cnt[0], ovr[0]} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_full: got c=%0d o=%b expected c=4 o=1", cnt[0], ovr[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if ({valid[0], data[0]} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL overrun_order[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, valid[0], data[0], 8'(i));
      end
      pop(0);
      if (i == 1) begin
        n_chk++;
        if (ovr[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL overrun_clear: got o=%b expected o=0", ovr[0]);
        end
      end
    end
    n_chk++;
    if (valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_drain: got v=%b expected v=0", valid[0]);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] d [5];
    int c;
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send_frame(0, d[i], 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (cnt[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_fill: got c=%0d expected c=4", cnt[0]);
    end
    fork
      send_frame(0, d[4], 1'b0, 1'b1, 1'b0);
      begin
        c = 0;
        while (c < 300 && st[0] !== 3'd4) begin
          @(negedge clk);
          c++;
        end
        if (c < 300) begin
          repeat (CPB - 1) @(negedge clk);
          pop(0);
        end
      end
    join
    repeat (3) @(negedge clk);
    n_chk++;
    if (c >= 300 || {cnt[0], ovr[0]} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL fullpop_count: got c=%0d o=%b wait=%0d expected c=4 o=0",
               cnt[0], ovr[0], c);
    end
    for (int i = 1; i < 5; i++) begin
      n_chk++;
      if ({valid[0], data[0]} !== {1'b1, d[i]}) begin
        n_fail++;
        $display("FAIL fullpop_order[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, valid[0], data[0], d[i]);
      end
      pop(0);
    end
  endtask

  task automatic test_random_back_to_back();
    int n;
    logic [7:0] d;
    logic p, s;
    logic [9:0] exp;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        n = $urandom_range(1, 4);
        mq.delete();
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          p = 1'($urandom);
          s = (k == 0) ? 1'($urandom) : 1'b1;
          send_frame(k, d, p, s, 1'b0);
          if (!s) repeat (3) @(negedge clk);
          mq.push_back(model_entry(k, d, p, s));
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (cnt[k] !== 3'(mq.size())) begin
          n_fail++;
          $display("FAIL rand_count[%0d.%0d]: got c=%0d expected c=%0d",
                   k, r, cnt[k], mq.size());
        end
        while (mq.size() > 0) begin
          exp = mq.pop_front();
          n_chk++;
          if (valid[k] !== 1'b1 || {data[k], ferr[k], perr[k]} !== exp) begin
            n_fail++;
            $display("FAIL rand_entry[%0d.%0d]: got v=%b entry=%h expected v=1 entry=%h",
                     k, r, valid[k], {data[k], ferr[k], perr[k]}, exp);
          end
          pop(k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hA6;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rxd[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd[0] = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd[0] = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset  = 1'b0;
    rxd[0] = 1'b1;
    #1;
    n_chk++;
    if ({valid[0], data[0], ferr[0], perr[0], ovr[0], cnt[0], st[0]} !== 17'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got v=%b d=%h f=%b p=%b o=%b c=%0d s=%0d expected all 0",
               valid[0], data[0], ferr[0], perr[0], ovr[0], cnt[0], st[0]);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if ({valid[0], data[0], ovr[0], cnt[0], st[0]} !== 15'd0) begin
      n_fail++;
      $display("FAIL midreset_after: got v=%b d=%h o=%b c=%0d s=%0d expected all 0",
               valid[0], data[0], ovr[0], cnt[0], st[0]);
    end
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({valid[0], data[0], ferr[0], cnt[0]} !== {1'b1, 8'h7E, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL midreset_next: got v=%b d=%h f=%b c=%0d expected v=1 d=7e f=0 c=1",
               valid[0], data[0], ferr[0], cnt[0]);
    end
    pop(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_overrun();
    test_full_pop();
    test_random_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
